// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : 5-stage pipeline sequencing (warm-up, load-use, flush,
//                        D-cache freeze + watchdog). Option: HAZARD_PERF_CNT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_rs1_i,
  input  logic [4:0]       IFID_rs2_i,
  input  logic [4:0]       IDEX_rd_i,
  input  logic             IDEX_MemRead_i,
  input  logic             branch_taken_i,
  input  logic             dcache_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             idex_stall_o,
  output logic             exmem_stall_o,
  output logic [1:0]       state_o,
  output logic             err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [WW-1:0] TIMEOUT_V = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERR      = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;

  logic w_init_mode;
  logic w_freeze;
  logic w_load_use;

  assign w_load_use = IDEX_MemRead_i && (IDEX_rd_i != 5'd0) &&
                      ((IDEX_rd_i == IFID_rs1_i) || (IDEX_rd_i == IFID_rs2_i));

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    w_init_mode = 1'b0;
    w_freeze    = 1'b0;
    case (state_q)
      S_INIT: begin
        w_init_mode = 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = S_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      S_RUN: begin
        if (dcache_busy_i) begin
          w_freeze   = 1'b1;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WW'(1);
        end
      end
      S_MEM_WAIT: begin
        if (dcache_busy_i) begin
          w_freeze = 1'b1;
          if (wait_cnt_q >= TIMEOUT_V) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
        end else begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end
      end
      S_ERR: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_init_mode = 1'b1;
      end
    endcase

    // Reset dominates the decode even though the state register clears one edge later
    if (rst_i) begin
      w_init_mode = 1'b1;
      w_freeze    = 1'b0;
    end

    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    idex_stall_o  = 1'b0;
    exmem_stall_o = 1'b0;
    if (w_init_mode) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (w_freeze) begin
      idex_stall_o  = 1'b1;
      exmem_stall_o = 1'b1;
    end else if (w_load_use) begin
      idex_bubble_o = 1'b1;
    end else begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      ifid_flush_o = branch_taken_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign state_o = state_q;
  assign err_o   = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             w_stall_ev;
  logic             w_flush_ev;

  assign w_stall_ev = ((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !pc_write_o;
  assign w_flush_ev = (state_q == S_RUN) && ifid_flush_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (w_stall_ev && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (w_flush_ev && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : directed vector bench for pipeline_hazard_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] O_INIT   = 6'b001100;
  localparam logic [5:0] O_NORM   = 6'b110000;
  localparam logic [5:0] O_FLUSH  = 6'b111000;
  localparam logic [5:0] O_BUBBLE = 6'b000100;
  localparam logic [5:0] O_FREEZE = 6'b000011;

  logic       clk = 1'b0;
  logic       rst;
  logic       mr, br, busy;
  logic [4:0] rd, rs1, rs2;

  logic       pcw_a, ifw_a, fl_a, bub_a, ids_a, exs_a, err_a;
  logic [1:0] st_a;
  logic       pcw_b, ifw_b, fl_b, bub_b, ids_b, exs_b, err_b;
  logic [1:0] st_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(255), .CNT_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_rs1_i(rs1), .IFID_rs2_i(rs2), .IDEX_rd_i(rd),
    .IDEX_MemRead_i(mr), .branch_taken_i(br), .dcache_busy_i(busy),
    .pc_write_o(pcw_a), .ifid_write_o(ifw_a), .ifid_flush_o(fl_a),
    .idex_bubble_o(bub_a), .idex_stall_o(ids_a), .exmem_stall_o(exs_a),
    .state_o(st_a), .err_o(err_a)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
`endif
  );

  pipeline_hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(3), .CNT_W(32)) u_dut_to (
    .clk_i(clk), .rst_i(rst),
    .IFID_rs1_i(rs1), .IFID_rs2_i(rs2), .IDEX_rd_i(rd),
    .IDEX_MemRead_i(mr), .branch_taken_i(br), .dcache_busy_i(busy),
    .pc_write_o(pcw_b), .ifid_write_o(ifw_b), .ifid_flush_o(fl_b),
    .idex_bubble_o(bub_b), .idex_stall_o(ids_b), .exmem_stall_o(exs_b),
    .state_o(st_b), .err_o(err_b)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
`endif
  );

  wire [5:0] o_a = {pcw_a, ifw_a, fl_a, bub_a, ids_a, exs_a};
  wire [5:0] o_b = {pcw_b, ifw_b, fl_b, bub_b, ids_b, exs_b};

  typedef struct {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       br;
    logic       busy;
    logic [5:0] exp_o;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic m, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic b, input logic bz);
    mr = m; rd = d; rs1 = s1; rs2 = s2; br = b; busy = bz;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset for n cycles, then check the two warm-up cycles; leaves both DUTs in RUN
  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_decode", {26'd0, o_a}, {26'd0, O_INIT});
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("init_decode", {26'd0, o_a}, {26'd0, O_INIT});
      chk("init_state", {30'd0, st_a}, 32'd0);
      chk("init_err", {31'd0, err_a}, 32'd0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    vecs[0]  = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, O_NORM,   2'd1};
    vecs[1]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, O_BUBBLE, 2'd1};
    vecs[2]  = '{1'b0, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, O_NORM,   2'd1};
    vecs[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_NORM,   2'd1};
    vecs[4]  = '{1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, O_BUBBLE, 2'd1};
    vecs[5]  = '{1'b0, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, O_FLUSH,  2'd1};
    vecs[6]  = '{1'b1, 5'd9, 5'd9, 5'd2, 1'b1, 1'b0, O_BUBBLE, 2'd1};
    vecs[7]  = '{1'b0, 5'd9, 5'd9, 5'd2, 1'b1, 1'b0, O_FLUSH,  2'd1};
    vecs[8]  = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, O_FREEZE, 2'd1};
    vecs[9]  = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, O_FREEZE, 2'd2};
    vecs[10] = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, O_BUBBLE, 2'd2};
    vecs[11] = '{1'b0, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, O_NORM,   2'd1};
    vecs[12] = '{1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, O_FREEZE, 2'd1};
    vecs[13] = '{1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, O_FLUSH,  2'd2};
    vecs[14] = '{1'b1, 5'd8, 5'd2, 5'd3, 1'b0, 1'b0, O_NORM,   2'd1};

    #1;
    do_reset(3);

    @(negedge clk);
    chk("run_after_init_state", {30'd0, st_a}, 32'd1);
    chk("run_after_init_out", {26'd0, o_a}, {26'd0, O_NORM});
    step();

    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].br, vecs[i].busy);
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), {26'd0, o_a}, {26'd0, vecs[i].exp_o});
      chk($sformatf("vec%0d_state", i), {30'd0, st_a}, {30'd0, vecs[i].exp_st});
      step();
    end

    // dcache busy for 4 cycles: freeze exactly 4 cycles, release cycle flows
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("busy4_c%0d_out", k), {26'd0, o_a}, {26'd0, O_FREEZE});
      step();
    end
    busy = 1'b0;
    @(negedge clk);
    chk("busy4_release_out", {26'd0, o_a}, {26'd0, O_NORM});
    chk("busy4_release_err", {31'd0, err_a}, 32'd0);
    step();
    @(negedge clk);
    chk("busy4_run_state", {30'd0, st_a}, 32'd1);
    step();

    // Watchdog with MEM_TIMEOUT=3 on the second instance
    do_reset(1);
    busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("to_c%0d_err", k), {31'd0, err_b}, (k >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("to_c%0d_state", k), {30'd0, st_b},
          (k == 0) ? 32'd1 : ((k < 4) ? 32'd2 : 32'd3));
      chk($sformatf("to_c%0d_out", k), {26'd0, o_b}, {26'd0, O_FREEZE});
      step();
    end
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("to_sticky_err", {31'd0, err_b}, 32'd1);
      chk("to_sticky_state", {30'd0, st_b}, 32'd3);
      chk("to_sticky_out", {26'd0, o_b}, {26'd0, O_FREEZE});
      chk("long_wait_no_err", {31'd0, err_a}, 32'd0);
      step();
    end

    // Reset out of ERR and out of MEM_WAIT
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", {31'd0, err_b}, 32'd0);
    chk("err_rst_state", {30'd0, st_b}, 32'd0);
    chk("mw_rst_state", {30'd0, st_a}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_rst_stall", scnt_a, 32'd0);
    chk("perf_rst_flush", fcnt_a, 32'd0);
`endif
    step();
    step();
    @(negedge clk);
    chk("post_err_run", {30'd0, st_b}, 32'd1);

`ifdef HAZARD_PERF_CNT_EN
    set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0);
    step();
    set_in(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0);
    step();
    set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
    step();
    set_in(1'b0, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
    step();
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1);
    repeat (4) step();
    busy = 1'b0;
    step();
    @(negedge clk);
    chk("perf_stall_cnt", scnt_a, 32'd6);
    chk("perf_flush_cnt", fcnt_a, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("perf_clr_stall", scnt_a, 32'd0);
    chk("perf_clr_flush", fcnt_a, 32'd0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
